// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_responder
//  Description : AXI4 slave memory endpoint. 256-bit single-beat and INCR
//                burst reads and writes into a word-addressed array that
//                starts at BASE_ADDR. The read and write channels run as
//                independent FSMs, and each direction allows one
//                outstanding transaction.
//  Ports       : ACLK/ARESETN         clock, synchronous active-low reset
//                AW*/W*/B*            write address, data and response
//                AR*/R*               read address and data
//  Revision    : 1.0  initial release
// ============================================================================
module axi_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          DATA_W    = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    // write address
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    // write data
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    // write response
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    // read address
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [31:0]           ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    // read data
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST
);

    localparam int          c_ADDR_W = $clog2(DEPTH);
    localparam int          c_STRB_W = DATA_W / 8;
    localparam logic [27:0] c_DEPTH  = 28'(DEPTH);
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode. Offsets are taken in whole 32-byte words. The extra
    // top bit holds the borrow, so an address below BASE_ADDR shows up
    // as bit 27 being set.
    // ------------------------------------------------------------------
    logic [27:0] w_aw_off, w_aw_end, w_ar_off, w_ar_end;
    logic        w_aw_err, w_ar_err;

    assign w_aw_off = {1'b0, AWADDR[31:5]} - {1'b0, BASE_ADDR[31:5]};
    assign w_aw_end = {1'b0, w_aw_off[26:0]} + {20'd0, AWLEN};
    assign w_aw_err = (AWADDR[4:0] != 5'd0) || (AWSIZE != 3'b101) ||
                      (AWBURST != 2'b01) || w_aw_off[27] || (w_aw_end >= c_DEPTH);

    assign w_ar_off = {1'b0, ARADDR[31:5]} - {1'b0, BASE_ADDR[31:5]};
    assign w_ar_end = {1'b0, w_ar_off[26:0]} + {20'd0, ARLEN};
    assign w_ar_err = (ARADDR[4:0] != 5'd0) || (ARSIZE != 3'b101) ||
                      (ARBURST != 2'b01) || w_ar_off[27] || (w_ar_end >= c_DEPTH);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t             r_wstate;
    logic                r_awready, r_wready, r_bvalid, r_werr;
    logic [1:0]          r_bresp;
    logic [c_ADDR_W-1:0] r_widx;
    logic [7:0]          r_wlen, r_wcnt;
    logic                w_wbeat, w_wfinal, w_wlast_bad, w_mem_we;

    assign w_wbeat     = (r_wstate == W_DATA) && WVALID && r_wready;
    assign w_wfinal    = (r_wcnt == r_wlen);
    // WLAST must be high on the counted final beat and only there
    assign w_wlast_bad = (WLAST != w_wfinal);
    // A flagged burst still drains by count but stops touching memory.
    // The current beat is judged against the flag as it stood before it.
    assign w_mem_we    = ARESETN && w_wbeat && !r_werr;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_werr    <= 1'b0;
            r_widx    <= '0;
            r_wlen    <= 8'd0;
            r_wcnt    <= 8'd0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (AWVALID && r_awready) begin
                        r_widx    <= w_aw_off[c_ADDR_W-1:0];
                        r_wlen    <= AWLEN;
                        r_wcnt    <= 8'd0;
                        r_werr    <= w_aw_err;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_wbeat) begin
                        r_widx <= r_widx + c_ADDR_W'(1);
                        r_wcnt <= r_wcnt + 8'd1;
                        if (w_wlast_bad) begin
                            r_werr <= 1'b1;
                        end
                        if (w_wfinal) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wlast_bad) ? c_SLVERR : c_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY && r_bvalid) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= c_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Memory is intentionally not reset
    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (WSTRB[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel. Each beat takes one fetch cycle and at least one
    // present cycle. A write to the same word on the fetch edge is not
    // visible, because the array update is non-blocking.
    // ------------------------------------------------------------------
    rstate_t             r_rstate;
    logic                r_arready, r_rvalid, r_rlast, r_rerr;
    logic [1:0]          r_rresp;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_ADDR_W-1:0] r_ridx;
    logic [7:0]          r_rlen, r_rcnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= c_OKAY;
            r_rdata   <= '0;
            r_rerr    <= 1'b0;
            r_ridx    <= '0;
            r_rlen    <= 8'd0;
            r_rcnt    <= 8'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (ARVALID && r_arready) begin
                        r_ridx    <= w_ar_off[c_ADDR_W-1:0];
                        r_rlen    <= ARLEN;
                        r_rcnt    <= 8'd0;
                        r_rerr    <= w_ar_err;
                        r_arready <= 1'b0;
                        r_rstate  <= R_FETCH;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    r_rdata  <= r_rerr ? '0 : r_mem[r_ridx];
                    r_rresp  <= r_rerr ? c_SLVERR : c_OKAY;
                    r_rlast  <= (r_rcnt == r_rlen);
                    r_rvalid <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (RREADY && r_rvalid) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_ridx   <= r_ridx + c_ADDR_W'(1);
                            r_rcnt   <= r_rcnt + 8'd1;
                            r_rstate <= R_FETCH;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_responder
//  Description : Self-checking bench for axi_mem_responder. It uses a
//                table of error-rule vectors, hand-written corner
//                sequences, and random traffic checked against an
//                array-based memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_mem_responder;

    localparam logic [31:0] BASE  = 32'hC000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [255:0] PAT  = 256'hDEAD_BEEF_CAFE_BABE_1122_3344_5566_7788_99AA_BBCC_DDEE_FF00_1234_5678_9ABC_DEF0;

    logic         ACLK, ARESETN;
    logic         AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [31:0]  AWADDR, ARADDR;
    logic [7:0]   AWLEN, ARLEN;
    logic [2:0]   AWSIZE, ARSIZE;
    logic [1:0]   AWBURST, ARBURST, BRESP, RRESP;
    logic [255:0] WDATA, RDATA;
    logic [31:0]  WSTRB;
    logic         ARVALID, ARREADY, RVALID, RREADY, RLAST;

    axi_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DATA_W(256)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    bit [255:0] m_mem [DEPTH];     // reference memory
    bit [255:0] g_wd [$];          // write beats for the next do_write
    bit [31:0]  g_ws [$];
    bit [255:0] g_rd [$];          // beats returned by the last do_read

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for handshake", name);
    endtask

    // Spec-level error rule: alignment, size, burst type, and word range
    function automatic bit model_err(logic [31:0] a, int len, logic [2:0] s, logic [1:0] b);
        longint sw;
        if (a[4:0] != 5'd0 || s != 3'b101 || b != 2'b01) return 1'b1;
        if (a < BASE) return 1'b1;
        sw = (longint'(a) - longint'(BASE)) / 32;
        return (sw + len) >= DEPTH;
    endfunction

    function automatic bit [255:0] rnd256();
        bit [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int early, input bit gaps,
                            input logic [1:0] exp, input string name);
        int n;
        int w0;
        logic [1:0] resp;
        AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        if (n >= 200) timeout({name, "_aw"});
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin WVALID = 1'b0; @(negedge ACLK); end
            WDATA = g_wd[i]; WSTRB = g_ws[i];
            WLAST = (early >= 0) ? (i == early) : (i == len);
            WVALID = 1'b1;
            n = 0;
            while (WREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
            if (n >= 200) timeout({name, "_w"});
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk({name, "_bvalid_latency"}, BVALID, 1'b1);
        BREADY = 1'b1;
        n = 0;
        while (BVALID !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        if (n >= 200) timeout({name, "_b"});
        resp = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk({name, "_bresp"}, resp, exp);
        if (exp == 2'b00) begin
            w0 = int'((addr - BASE) >> 5);
            for (int i = 0; i <= len; i++)
                for (int b = 0; b < 32; b++)
                    if (g_ws[i][b]) m_mem[w0 + i][b*8 +: 8] = g_wd[i][b*8 +: 8];
        end
    endtask

    // mode 0: RREADY always high, 1: toggling, 2: random
    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode, input logic [1:0] exp,
                           input string name);
        int n, got, limit, w0;
        bit rr, tog, stall;
        logic [255:0] pd, ed;
        logic pl;
        logic [1:0] pr;
        g_rd.delete();
        ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        if (n >= 200) timeout({name, "_ar"});
        @(negedge ACLK);
        ARVALID = 1'b0;
        w0 = (exp == 2'b00) ? int'((addr - BASE) >> 5) : 0;
        got = 0; n = 0; stall = 1'b0; tog = 1'b1; pd = '0; pl = 1'b0; pr = 2'b00;
        limit = 20 * (len + 1) + 20;
        while (got <= len && n < limit) begin
            if (stall) chk({name, "_stall_hold"}, {RVALID, RLAST, RRESP, RDATA}, {1'b1, pl, pr, pd});
            case (mode)
                0:       rr = 1'b1;
                1:       begin rr = tog; tog = !tog; end
                default: rr = 1'($urandom_range(0, 1));
            endcase
            if (RVALID === 1'b1) begin
                if (rr) begin
                    ed = (exp == 2'b00) ? m_mem[w0 + got] : '0;
                    chk({name, "_rdata"}, RDATA, ed);
                    chk({name, "_rresp"}, RRESP, exp);
                    chk({name, "_rlast"}, RLAST, (got == len));
                    g_rd.push_back(RDATA);
                    got++;
                end
                stall = !rr; pd = RDATA; pl = RLAST; pr = RRESP;
            end else begin
                stall = 1'b0;
            end
            RREADY = rr;
            @(negedge ACLK);
            n++;
        end
        RREADY = 1'b0;
        if (got <= len) timeout({name, "_r"});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp;

        vt[0] = '{32'hC000_0000, 0, 3'b101, 2'b01, 2'b00};
        vt[1] = '{32'h0000_0000, 0, 3'b101, 2'b01, 2'b10};
        vt[2] = '{32'hC000_0001, 1, 3'b101, 2'b01, 2'b10};
        vt[3] = '{32'hC000_0020, 0, 3'b100, 2'b01, 2'b10};
        vt[4] = '{32'hC000_0020, 0, 3'b101, 2'b10, 2'b10};
        vt[5] = '{32'hC000_7F80, 3, 3'b101, 2'b01, 2'b00};   // ends on word DEPTH-1
        vt[6] = '{32'hC000_7F80, 4, 3'b101, 2'b01, 2'b10};   // ends on word DEPTH
        vt[7] = '{32'hC000_8000, 0, 3'b101, 2'b01, 2'b10};   // starts past the end
        vt[8] = '{32'hBFFF_FFE0, 1, 3'b101, 2'b01, 2'b10};   // below base
        vt[9] = '{32'hC000_7FE0, 0, 3'b101, 2'b01, 2'b00};   // last word

        ARESETN = 1'b0;
        AWVALID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        WVALID = 0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
        repeat (3) @(negedge ACLK);
        chk("reset_ctrl", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RLAST}, '0);
        chk("reset_rdata", RDATA, '0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Preload the array with four maximal 256-beat bursts
        for (int k = 0; k < 4; k++) begin
            g_wd.delete(); g_ws.delete();
            for (int i = 0; i < 256; i++) begin
                g_wd.push_back(rnd256());
                g_ws.push_back(32'hFFFF_FFFF);
            end
            do_write(BASE + 32'(k * 256 * 32), 255, 3'b101, 2'b01, -1, 1'b0, 2'b00, "preload");
        end

        // Single write then read of the reference pattern
        g_wd = '{PAT}; g_ws = '{32'hFFFF_FFFF};
        do_write(BASE, 0, 3'b101, 2'b01, -1, 1'b0, 2'b00, "single_wr");
        do_read(BASE, 0, 3'b101, 2'b01, 0, 2'b00, "single_rd");
        if (g_rd.size() == 1) chk("single_pattern", g_rd[0], PAT);
        else timeout("single_pattern");

        // Partial strobe clears only the low four bytes
        g_wd = '{256'd0}; g_ws = '{32'h0000_000F};
        do_write(BASE, 0, 3'b101, 2'b01, -1, 1'b0, 2'b00, "strobe_wr");
        do_read(BASE, 0, 3'b101, 2'b01, 0, 2'b00, "strobe_rd");
        if (g_rd.size() == 1) chk("strobe_pattern", g_rd[0], PAT & ~256'hFFFF_FFFF);
        else timeout("strobe_pattern");

        // Gapped 4-beat write, then read with RREADY toggling
        g_wd = '{256'd1, 256'd2, 256'd3, 256'd4};
        g_ws = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        do_write(32'hC000_0040, 3, 3'b101, 2'b01, -1, 1'b1, 2'b00, "burst_wr");
        do_read(32'hC000_0040, 3, 3'b101, 2'b01, 1, 2'b00, "burst_rd");
        if (g_rd.size() == 4)
            for (int i = 0; i < 4; i++) chk("burst_order", g_rd[i], 256'(i + 1));
        else timeout("burst_order");

        // Early WLAST on the first beat of a 3-beat write
        g_wd = '{rnd256(), rnd256(), rnd256()}; g_ws = '{32'h0, 32'h0, 32'h0};
        do_write(32'hC000_0400, 2, 3'b101, 2'b01, 0, 1'b0, 2'b10, "early_wlast");

        // Error-rule vector table: each entry is written and then read back
        foreach (vt[v]) begin
            g_wd.delete(); g_ws.delete();
            for (int i = 0; i <= vt[v].len; i++) begin
                g_wd.push_back(rnd256());
                g_ws.push_back(32'hFFFF_FFFF);
            end
            do_write(vt[v].addr, vt[v].len, vt[v].size, vt[v].burst, -1, 1'b0, vt[v].exp, "vec_wr");
            do_read(vt[v].addr, vt[v].len, vt[v].size, vt[v].burst, 2, vt[v].exp, "vec_rd");
        end
        do_read(BASE, 1, 3'b101, 2'b01, 0, 2'b00, "err_mem_unchanged");

        // Concurrency: the write to word 5 lands on the same edge as its fetch
        g_wd = '{{32{8'h55}}}; g_ws = '{32'hFFFF_FFFF};
        do_write(BASE + 32'hA0, 0, 3'b101, 2'b01, -1, 1'b0, 2'b00, "conc_pre");
        AWADDR = BASE + 32'hA0; AWLEN = 0; AWSIZE = 3'b101; AWBURST = 2'b01; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        if (n >= 200) timeout("conc_aw");
        @(negedge ACLK);
        AWVALID = 1'b0;
        ARADDR = BASE + 32'hA0; ARLEN = 0; ARSIZE = 3'b101; ARBURST = 2'b01; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        if (n >= 200) timeout("conc_ar");
        @(negedge ACLK);
        ARVALID = 1'b0;
        WDATA = {32{8'hAA}}; WSTRB = 32'hFFFF_FFFF; WLAST = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
        chk("conc_rvalid", RVALID, 1'b1);
        chk("conc_old_data", RDATA, {32{8'h55}});
        chk("conc_bvalid", {BVALID, BRESP}, 3'b100);
        RREADY = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0; BREADY = 1'b0;
        m_mem[5] = {32{8'hAA}};
        do_read(BASE + 32'hA0, 0, 3'b101, 2'b01, 0, 2'b00, "conc_new");
        if (g_rd.size() == 1) chk("conc_new_data", g_rd[0], {32{8'hAA}});
        else timeout("conc_new_data");

        // Random traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 32);
            len = $urandom_range(0, 7); size = 3'b101; burst = 2'b01;
            case ($urandom_range(0, 9))
                0: addr = addr | 32'($urandom_range(1, 31));
                1: size = 3'($urandom_range(0, 4));
                2: burst = 2'b10;
                3: len = $urandom_range(0, 40);
                default: ;
            endcase
            exp = model_err(addr, len, size, burst) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                g_wd.delete(); g_ws.delete();
                for (int i = 0; i <= len; i++) begin
                    g_wd.push_back(rnd256());
                    g_ws.push_back($urandom);
                end
                do_write(addr, len, size, burst, -1, 1'($urandom_range(0, 1)), exp, "rand_wr");
            end else begin
                do_read(addr, len, size, burst, $urandom_range(0, 2), exp, "rand_rd");
            end
        end

        // Reset pulse during beat 2 of an 8-beat read
        ARADDR = BASE + 32'h100; ARLEN = 7; ARSIZE = 3'b101; ARBURST = 2'b01; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
        if (n >= 200) timeout("rst_ar");
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        n = 0;
        while (RVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("rst_beat1");
        @(negedge ACLK);
        n = 0;
        while (RVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) timeout("rst_beat2");
        ARESETN = 1'b0; RREADY = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        chk("rst_mid_outs", {RVALID, AWREADY, ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("rst_mid_arready", ARREADY, 1'b1);
        do_read(BASE + 32'h200, 1, 3'b101, 2'b01, 0, 2'b00, "post_rst_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
